stopwatch_controller: RTL
=========================

# stopwatch_controller

Sequencing controller for the two-digit seven-segment counter datapath. It debounces a start/stop button and a clear button and runs a RUN/PAUSE/IDLE state machine. A prescaler paces count increments, and the block maintains the 00–99 count directly as two BCD digits (no divide/modulo). The `tens`/`ones` outputs feed the existing `seven_segment_decode` instances.

## Interface
- `DB_WIDTH`, 18: debounce counter width; a press is accepted after 2^DB_WIDTH−1 consecutive high cycles.
- `TICK_DIV`, 100: clock cycles per count increment while running; must be ≥ 2.
- `clock`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-high reset.
- `btn_start`  input  1  start/stop toggle button, active-high, synchronous to `clock`.
- `btn_clear`  input  1  clear button, active-high.
- `btn_lap`  input  1  lap button; present only with `STOPWATCH_LAP_EN`.
- `tens`  output  4  displayed BCD tens digit, 0–9.
- `ones`  output  4  displayed BCD ones digit, 0–9.
- `running`  output  1  high while in RUN.
- `wrap_pulse`  output  1  one-cycle pulse on the 99→00 rollover.

## Operation
- **Debounce, per button:** independent `DB_WIDTH` counter.
  - Button low: counter cleared to 0.
  - Button high: counter increments, saturating at all-ones.
  - Press pulse = button high AND counter == all-ones−1. This gives exactly one pulse per held press, and none again until release.
- **States:** IDLE, RUN, PAUSE. Encoding is free.
  - IDLE + start → RUN.
  - RUN + start → PAUSE.
  - PAUSE + start → RUN.
  - IDLE or PAUSE + clear → IDLE; count := 00, prescaler := 0.
  - RUN + clear: ignored.
  - Start and clear pulses in the same cycle:
    - In IDLE or PAUSE, clear wins.
    - In RUN, start wins (→ PAUSE) and clear is dropped.
- **Prescaler:** counts 0..`TICK_DIV`−1 in RUN only.
  - At `TICK_DIV`−1 it returns to 0 and the count increments.
  - In PAUSE it holds its value; in IDLE it is 0.
- **Count (BCD):**
  - Ones 9 → 0 carries into tens.
  - At 99, increment → 00 and `wrap_pulse` asserts for one cycle. Counting continues.
  - Digits never leave 0–9.
- **Outputs:** `running` = (state == RUN).

## Timing
- **Reset values:** state IDLE; `tens` = `ones` = 0; `running` = 0; `wrap_pulse` = 0; all debounce counters and the prescaler 0.
- **Reset mid-operation:** abandons the count and any partial press immediately. The same button held through reset deassertion must re-debounce from 0.
- **Press acceptance:** with button high from cycle 0, the state change is visible after rising edge 2^DB_WIDTH−1.
- **Registered outputs:** all outputs come from flops. `running` changes on the same edge as the state.
- **Increment latency:** the first increment after entering RUN from IDLE is `TICK_DIV` edges after the entering edge.
- **Pause/resume:** resuming from PAUSE completes the remaining `TICK_DIV`−p cycles, where p is the prescaler value held at pause.
- **Wrap timing:** `wrap_pulse` is high during the cycle in which the outputs show 00 after rollover.

## Configuration
- **`STOPWATCH_LAP_EN` defined:**
  - Adds `btn_lap` with its own debouncer and a lap-hold flag.
  - A lap press in RUN while the flag is clear sets the flag. `tens`/`ones` then freeze at the live count of that edge while internal counting continues.
  - A second lap press, or any transition to IDLE, clears the flag and returns to the live count.
  - A lap press in IDLE or PAUSE is ignored.
  - `wrap_pulse` follows the live count.
- **Undefined:** no `btn_lap` port, no lap logic; `tens`/`ones` always show the live count.

## Test plan
1. **Start then count** (`DB_WIDTH`=4, `TICK_DIV`=4): reset, hold `btn_start` 20 cycles.
   - `running` rises after edge 15.
   - `ones` reaches 1 four edges later.
   - Exactly one state change for the whole hold.
2. **Bounce rejection:** toggle `btn_start` high 10 / low 1 repeatedly for 200 cycles → state stays IDLE, count 00.
3. **Wrap:** run from 00 for 100×`TICK_DIV` cycles.
   - Sequence passes 09→10 and 99→00.
   - `wrap_pulse` is high for exactly one cycle, coincident with 00.
4. **Pause/clear:**
   - Press start at count 37 → PAUSE; count holds at 37 for 1000 cycles.
   - Press clear → IDLE, count 00.
   - Clear pressed during RUN leaves the count unaffected.
5. **Simultaneous and reset:**
   - Start+clear in the same cycle in PAUSE → IDLE, 00.
   - Same pair in RUN → PAUSE with count kept.
   - Assert `reset` mid-count at 52 → 00, IDLE, immediately.
6. **Lap** (`STOPWATCH_LAP_EN`):
   - Lap at 12 → outputs hold 12 while the internal count advances to 20.
   - Second lap → outputs show 20.

Source files
------------

// File: rtl/stopwatch_controller_if.sv
// Button inputs and display outputs of stopwatch_controller.
// btn_lap exists only when STOPWATCH_LAP_EN is defined.
interface stopwatch_controller_if;
  logic       btn_start;
  logic       btn_clear;
`ifdef STOPWATCH_LAP_EN
  logic       btn_lap;
`endif
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       wrap_pulse;

`ifdef STOPWATCH_LAP_EN
  modport master (output btn_start, btn_clear, btn_lap, input tens, ones, running, wrap_pulse);
  modport slave  (input btn_start, btn_clear, btn_lap, output tens, ones, running, wrap_pulse);
`else
  modport master (output btn_start, btn_clear, input tens, ones, running, wrap_pulse);
  modport slave  (input btn_start, btn_clear, output tens, ones, running, wrap_pulse);
`endif
endinterface

// File: rtl/stopwatch_controller.sv
// Debounced start/clear buttons drive an IDLE/RUN/PAUSE FSM pacing a 00-99 BCD count.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_EN.
module stopwatch_controller #(
  parameter int unsigned DB_WIDTH = 18,
  parameter int unsigned TICK_DIV = 100
) (
  input logic                   clock,
  input logic                   reset,
  stopwatch_controller_if.slave sw
);
  localparam int unsigned          PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0]        PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [DB_WIDTH-1:0]  DB_ARM  = {{(DB_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_e;

  // Saturating run-length counter; cleared whenever the button is released.
  function automatic logic [DB_WIDTH-1:0] db_next(input logic btn, input logic [DB_WIDTH-1:0] cnt);
    if (!btn)
      db_next = '0;
    else if (cnt == {DB_WIDTH{1'b1}})
      db_next = cnt;
    else
      db_next = cnt + {{(DB_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_e              state_q, state_d;
  logic [DB_WIDTH-1:0] db_start_q, db_start_d, db_clear_q, db_clear_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [3:0]          tens_q, tens_d, ones_q, ones_d;
  logic                running_q, running_d, wrap_q, wrap_d;
  logic                start_p, clear_p;

  assign start_p = sw.btn_start && (db_start_q == DB_ARM);
  assign clear_p = sw.btn_clear && (db_clear_q == DB_ARM);

`ifdef STOPWATCH_LAP_EN
  logic [DB_WIDTH-1:0] db_lap_q, db_lap_d;
  logic                lap_hold_q, lap_hold_d, lap_p;
  logic [3:0]          disp_tens_q, disp_tens_d, disp_ones_q, disp_ones_d;
  assign lap_p = sw.btn_lap && (db_lap_q == DB_ARM);
`endif

  // State register and all datapath flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      db_start_q <= '0;
      db_clear_q <= '0;
      presc_q    <= '0;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      running_q  <= 1'b0;
      wrap_q     <= 1'b0;
`ifdef STOPWATCH_LAP_EN
      db_lap_q    <= '0;
      lap_hold_q  <= 1'b0;
      disp_tens_q <= 4'd0;
      disp_ones_q <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      db_start_q <= db_start_d;
      db_clear_q <= db_clear_d;
      presc_q    <= presc_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      running_q  <= running_d;
      wrap_q     <= wrap_d;
`ifdef STOPWATCH_LAP_EN
      db_lap_q    <= db_lap_d;
      lap_hold_q  <= lap_hold_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
`endif
    end
  end

  // Next state: clear beats start outside RUN, start alone matters inside RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clear_p) state_d = S_IDLE;  else if (start_p) state_d = S_RUN; else state_d = S_IDLE;
      S_RUN:   if (start_p) state_d = S_PAUSE; else state_d = S_RUN;
      S_PAUSE: if (clear_p) state_d = S_IDLE;  else if (start_p) state_d = S_RUN; else state_d = S_PAUSE;
      default: state_d = S_IDLE;
    endcase
  end

  // Debouncers, prescaler, BCD count and registered outputs.
  always_comb begin
    db_start_d = db_next(sw.btn_start, db_start_q);
    db_clear_d = db_next(sw.btn_clear, db_clear_q);
    presc_d    = presc_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    wrap_d     = 1'b0;
    running_d  = (state_d == S_RUN);
    if (state_q == S_RUN) begin
      if (presc_q == PRE_MAX) begin
        presc_d = '0;
        if (ones_q == 4'd9) begin
          ones_d = 4'd0;
          if (tens_q == 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else if (clear_p) begin
      presc_d = '0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
    end else begin
      presc_d = presc_q;
    end
  end

`ifdef STOPWATCH_LAP_EN
  // Lap hold: freeze the display at the live count of the capturing edge.
  always_comb begin
    db_lap_d = db_next(sw.btn_lap, db_lap_q);
    if (lap_hold_q && lap_p)
      lap_hold_d = 1'b0;
    else if (!lap_hold_q && lap_p && (state_q == S_RUN))
      lap_hold_d = 1'b1;
    else
      lap_hold_d = lap_hold_q;
    if (state_d == S_IDLE)
      lap_hold_d = 1'b0;
    if (lap_hold_d && lap_hold_q) begin
      disp_tens_d = disp_tens_q;
      disp_ones_d = disp_ones_q;
    end else begin
      disp_tens_d = tens_d;
      disp_ones_d = ones_d;
    end
  end

  assign sw.tens = disp_tens_q;
  assign sw.ones = disp_ones_q;
`else
  assign sw.tens = tens_q;
  assign sw.ones = ones_q;
`endif
  assign sw.running    = running_q;
  assign sw.wrap_pulse = wrap_q;
endmodule
